// File: rtl/strait_pkg.sv
// rtl/strait_pkg.sv - shared types and sizing helpers for the fault map loader
package strait_pkg;

  // Load sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    ALLOC  = 2'd3
  } fault_map_state_t;

  // Counter width able to hold every PE of a size x size array being faulty
  function automatic int fault_cnt_width(input int size);
    return $clog2(size * size + 1);
  endfunction

endpackage

// File: rtl/fault_popcount.sv
// rtl/fault_popcount.sv - combinational popcount over the flattened fault map
module fault_popcount #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 7
) (
  input  logic [WIDTH-1:0]     bits,
  output logic [CNT_WIDTH-1:0] count
);

  // Sum every bit of the map
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_WIDTH'(bits[i]);
    end
  end

endmodule

// File: rtl/fault_map_loader.sv
// rtl/fault_map_loader.sv - holds the per-PE fault map and streams it row by row into BISR (option: STRAIT_FAULT_COUNT_EN)
module fault_map_loader
  import strait_pkg::*;
#(
  parameter int SYSTOLIC_SIZE   = 8,
  parameter int ADDR_WIDTH      = $clog2(SYSTOLIC_SIZE),
  parameter int FAULT_CNT_WIDTH = fault_cnt_width(SYSTOLIC_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cap_valid,
  input  logic [ADDR_WIDTH-1:0]      cap_row_addr,
  input  logic [SYSTOLIC_SIZE-1:0]   cap_row_faults,
  output logic                       cap_ready,
  input  logic                       map_clear,
  input  logic                       load_start,
  input  logic                       bisr_ready,
  output logic                       envm_wr_en,
  output logic [ADDR_WIDTH-1:0]      envm_wr_addr,
  output logic [SYSTOLIC_SIZE-1:0]   envm_faulty_patterns_flat,
  output logic                       allocation_start,
  output logic                       busy,
  output logic                       load_done,
  output logic [FAULT_CNT_WIDTH-1:0] fault_count
);

  localparam int                    MAP_BITS = SYSTOLIC_SIZE * SYSTOLIC_SIZE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

  fault_map_state_t           state;
  fault_map_state_t           state_next;
  logic [MAP_BITS-1:0]        map_q;
  logic [MAP_BITS-1:0]        map_next;
  logic [ADDR_WIDTH-1:0]      row_cnt;
  logic [SYSTOLIC_SIZE-1:0]   row_data;
  logic                       row_issue;

  // A row goes out on every STREAM cycle that BISR can take it
  assign row_issue = (state == STREAM) && bisr_ready;
  assign row_data  = map_q[row_cnt * SYSTOLIC_SIZE +: SYSTOLIC_SIZE];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: stream all rows, then one drain cycle, then the allocation pulse
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_start) state_next = STREAM;
      STREAM:  if (row_issue && (row_cnt == LAST_ROW)) state_next = DRAIN;
      DRAIN:   state_next = ALLOC;
      ALLOC:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded directly from the state register
  always_comb begin
    cap_ready        = (state == IDLE);
    busy             = (state != IDLE);
    allocation_start = (state == ALLOC);
  end

  // Map update: clear first, then OR the capture in, so a same-cycle clear keeps the new row
  always_comb begin
    map_next = map_q;
    if (state == IDLE) begin
      if (map_clear) begin
        map_next = '0;
      end
      if (cap_valid && (int'(cap_row_addr) < SYSTOLIC_SIZE)) begin
        map_next[int'(cap_row_addr) * SYSTOLIC_SIZE +: SYSTOLIC_SIZE] =
          map_next[int'(cap_row_addr) * SYSTOLIC_SIZE +: SYSTOLIC_SIZE] | cap_row_faults;
      end
    end
  end

  // Map storage, row counter and the registered BISR write port
  always_ff @(posedge clk) begin
    if (rst) begin
      map_q                     <= '0;
      row_cnt                   <= '0;
      envm_wr_en                <= 1'b0;
      envm_wr_addr              <= '0;
      envm_faulty_patterns_flat <= '0;
      load_done                 <= 1'b0;
    end else begin
      map_q <= map_next;
      if ((state == IDLE) && load_start) begin
        row_cnt <= '0;
      end else if (row_issue) begin
        row_cnt <= row_cnt + 1'b1;
      end
      envm_wr_en                <= row_issue;
      envm_wr_addr              <= row_issue ? row_cnt : '0;
      envm_faulty_patterns_flat <= row_issue ? row_data : '0;
      load_done                 <= (state == ALLOC);
    end
  end

`ifdef STRAIT_FAULT_COUNT_EN
  logic [FAULT_CNT_WIDTH-1:0] pop_count;

  fault_popcount #(
    .WIDTH     (MAP_BITS),
    .CNT_WIDTH (FAULT_CNT_WIDTH)
  ) u_fault_popcount (
    .bits  (map_q),
    .count (pop_count)
  );

  // Registered fault total, trails the map by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_count <= '0;
    end else begin
      fault_count <= pop_count;
    end
  end
`else
  assign fault_count = '0;
`endif

endmodule

// File: tb/tb_fault_map_loader.sv
// tb/tb_fault_map_loader.sv - self-checking bench for fault_map_loader
module tb_fault_map_loader;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          cap_valid;
  logic [AW-1:0] cap_row_addr;
  logic [N-1:0]  cap_row_faults;
  logic          cap_ready;
  logic          map_clear;
  logic          load_start;
  logic          bisr_ready;
  logic          envm_wr_en;
  logic [AW-1:0] envm_wr_addr;
  logic [N-1:0]  envm_faulty_patterns_flat;
  logic          allocation_start;
  logic          busy;
  logic          load_done;
  logic [CW-1:0] fault_count;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] mdl [N];

  always #5 clk = ~clk;

  fault_map_loader #(.SYSTOLIC_SIZE(N)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .cap_valid                 (cap_valid),
    .cap_row_addr              (cap_row_addr),
    .cap_row_faults            (cap_row_faults),
    .cap_ready                 (cap_ready),
    .map_clear                 (map_clear),
    .load_start                (load_start),
    .bisr_ready                (bisr_ready),
    .envm_wr_en                (envm_wr_en),
    .envm_wr_addr              (envm_wr_addr),
    .envm_faulty_patterns_flat (envm_faulty_patterns_flat),
    .allocation_start          (allocation_start),
    .busy                      (busy),
    .load_done                 (load_done),
    .fault_count               (fault_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_count();
    int c = 0;
    for (int r = 0; r < N; r++) c += $countones(mdl[r]);
`ifdef STRAIT_FAULT_COUNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic capture(input int row, input logic [N-1:0] val, input bit clr);
    @(negedge clk);
    cap_valid      = 1'b1;
    cap_row_addr   = AW'(row);
    cap_row_faults = val;
    map_clear      = clr;
    if (clr) for (int r = 0; r < N; r++) mdl[r] = '0;
    mdl[row] = mdl[row] | val;
    @(negedge clk);
    cap_valid = 1'b0;
    map_clear = 1'b0;
  endtask

  task automatic check_count(input string tag);
    @(negedge clk);
    check(tag, 32'(fault_count), 32'(exp_count()));
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,..., 2: random ready
  task automatic do_load(input int mode, input bit disturb, input bit cap_with_start,
                         input logic [N-1:0] start_val);
    bit seq[$];
    int ones = 0;
    int s;
    int widx = 0;
    bit exp_wr;
    while (ones < N) begin
      bit r;
      case (mode)
        0:       r = 1'b1;
        1:       r = (seq.size() % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      seq.push_back(r);
      ones += int'(r);
    end
    s = seq.size();
    @(negedge clk);
    load_start = 1'b1;
    bisr_ready = 1'b0;
    if (cap_with_start) begin
      cap_valid      = 1'b1;
      cap_row_addr   = '0;
      cap_row_faults = start_val;
      mdl[0]         = mdl[0] | start_val;
    end
    for (int k = 1; k <= s + 5; k++) begin
      @(negedge clk);
      exp_wr = (k >= 2) && (k - 1 <= s) && seq[k-2];
      check("wr_en", 32'(envm_wr_en), 32'(exp_wr));
      if (exp_wr) begin
        if (envm_wr_en) begin
          check("wr_addr", 32'(envm_wr_addr), 32'(widx));
          check("wr_data", 32'(envm_faulty_patterns_flat), 32'(mdl[widx]));
        end
        widx++;
      end
      check("alloc", 32'(allocation_start), 32'(k == s + 2));
      check("done", 32'(load_done), 32'(k == s + 3));
      check("busy", 32'(busy), 32'(k <= s + 2));
      check("cap_ready", 32'(cap_ready), 32'(k > s + 2));
      load_start     = disturb && (k == 2);
      cap_valid      = disturb && (k == 2);
      cap_row_addr   = AW'(1);
      cap_row_faults = '1;
      bisr_ready     = (k <= s) ? seq[k-1] : 1'($urandom_range(0, 1));
    end
    check("nwrites", 32'(widx), 32'(N));
    bisr_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cap_valid = 1'b0; cap_row_addr = '0; cap_row_faults = '0;
    map_clear = 1'b0; load_start = 1'b0; bisr_ready = 1'b0;
    for (int r = 0; r < N; r++) mdl[r] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cap_ready", 32'(cap_ready), 32'd1);
    check("rst_wr_en", 32'(envm_wr_en), 32'd0);
    check("rst_alloc", 32'(allocation_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_count", 32'(fault_count), 32'd0);

    capture(3, 8'h12, 1'b0);
    check_count("cnt_basic");
    do_load(0, 1'b0, 1'b0, '0);

    capture(5, 8'h01, 1'b0);
    capture(5, 8'h80, 1'b0);
    check("mdl_or", 32'(mdl[5]), 32'h81);
    do_load(0, 1'b0, 1'b0, '0);

    capture(2, 8'hFF, 1'b1);
    check_count("cnt_clear");
    do_load(0, 1'b0, 1'b0, '0);

    do_load(1, 1'b0, 1'b0, '0);

    do_load(0, 1'b1, 1'b0, '0);
    check_count("cnt_busy");

    do_load(0, 1'b0, 1'b1, 8'h04);

    for (int i = 0; i < 4; i++) begin
      capture(int'($urandom_range(0, N - 1)), N'($urandom), 1'b0);
      capture(int'($urandom_range(0, N - 1)), N'($urandom), 1'b0);
      check_count("cnt_rand");
      do_load(2, 1'b0, 1'b0, '0);
    end

    @(negedge clk);
    load_start = 1'b1;
    bisr_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      load_start = 1'b0;
    end
    check("pre_rst_wr_en", 32'(envm_wr_en), 32'd1);
    check("pre_rst_addr", 32'(envm_wr_addr), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bisr_ready = 1'b0;
    for (int r = 0; r < N; r++) mdl[r] = '0;
    check("mrst_wr_en", 32'(envm_wr_en), 32'd0);
    check("mrst_addr", 32'(envm_wr_addr), 32'd0);
    check("mrst_data", 32'(envm_faulty_patterns_flat), 32'd0);
    check("mrst_alloc", 32'(allocation_start), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(load_done), 32'd0);
    check("mrst_count", 32'(fault_count), 32'd0);
    check("mrst_cap_ready", 32'(cap_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mrst_no_alloc", 32'(allocation_start), 32'd0);
      check("mrst_no_done", 32'(load_done), 32'd0);
    end
    do_load(0, 1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
